// File: rtl/mips_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mips_ctrl_pkg
// Shared definitions for the multi-cycle MIPS sequencer:
//   - opcode / funct encodings of the supported instruction subset
//   - ALUcontrol codes driven to the Datapath
//   - sequencer state encoding and instruction classes
//   - decoded static control bundle
//   - jump target helper
// -----------------------------------------------------------------------------
package mips_ctrl_pkg;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes
    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // ALUcontrol codes
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;
    localparam logic [2:0] ALU_SLL = 3'b101;
    localparam logic [2:0] ALU_SRL = 3'b110;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_e;

    // Instruction class decides the phase sequence after DECODE
    typedef enum logic [2:0] {
        CLS_ALU  = 3'd0,   // R-type and ALU-immediate: EXEC -> WB
        CLS_LW   = 3'd1,   // EXEC -> MEM -> WB
        CLS_SW   = 3'd2,   // EXEC -> MEM
        CLS_BEQ  = 3'd3,   // EXEC only
        CLS_J    = 3'd4,   // resolved in DECODE
        CLS_HALT = 3'd5,
        CLS_NONE = 3'd6    // unsupported encoding
    } iclass_e;

    // Static controls, constant for the life of one instruction
    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic [2:0] alu_ctrl;
        logic       sign1;
        logic       sign2;
        logic       shift;
        logic       mem_to_reg;
    } ctrl_t;

    // j target: keep the PC region bits, word-align the 26-bit index
    function automatic logic [31:0] jump_target(input logic [3:0] pc_hi, input logic [25:0] index);
        return {pc_hi, index, 2'b00};
    endfunction

endpackage

// File: rtl/mips_decoder.sv
// -----------------------------------------------------------------------------
// mips_decoder
// Combinational decode of opcode/funct into static Datapath controls, the
// instruction class that steers the sequencer, and a legal flag.
// Ports:
//   opcode_i  in  6   IR[31:26]
//   funct_i   in  6   IR[5:0]
//   ctrl_o    out     static control bundle (ctrl_t)
//   class_o   out     instruction class (iclass_e)
//   legal_o   out 1   0 for an unsupported opcode or R-type funct
// -----------------------------------------------------------------------------
module mips_decoder
    import mips_ctrl_pkg::*;
#(
    parameter logic [5:0] HALT_OPCODE = 6'h3F
) (
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output ctrl_t      ctrl_o,
    output iclass_e    class_o,
    output logic       legal_o
);

    // Opcode/funct decode; every path starts from all-zero controls
    always_comb begin
        ctrl_o  = '0;
        class_o = CLS_NONE;
        legal_o = 1'b1;
        // The halt opcode is checked first so it wins over any overlapping encoding
        if (opcode_i == HALT_OPCODE) begin
            class_o = CLS_HALT;
        end else begin
            case (opcode_i)
                OP_RTYPE: begin
                    class_o        = CLS_ALU;
                    ctrl_o.reg_dst = 1'b1;
                    ctrl_o.alu_src = 1'b0;
                    ctrl_o.sign1   = 1'b0;
                    case (funct_i)
                        FN_ADD:  ctrl_o.alu_ctrl = ALU_ADD;
                        FN_SUB:  ctrl_o.alu_ctrl = ALU_SUB;
                        FN_AND:  ctrl_o.alu_ctrl = ALU_AND;
                        FN_OR:   ctrl_o.alu_ctrl = ALU_OR;
                        FN_SLT:  ctrl_o.alu_ctrl = ALU_SLT;
                        FN_SLL: begin
                            ctrl_o.alu_ctrl = ALU_SLL;
                            ctrl_o.shift    = 1'b1;
                        end
                        FN_SRL: begin
                            ctrl_o.alu_ctrl = ALU_SRL;
                            ctrl_o.shift    = 1'b1;
                        end
                        default: begin
                            class_o = CLS_NONE;
                            legal_o = 1'b0;
                        end
                    endcase
                end
                OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI: begin
                    class_o        = CLS_ALU;
                    ctrl_o.reg_dst = 1'b0;
                    ctrl_o.alu_src = 1'b1;
                    // addi traps on signed overflow, addiu does not; both sign-extend
                    ctrl_o.sign1   = (opcode_i == OP_ADDI) ? 1'b1 : 1'b0;
                    ctrl_o.sign2   = (opcode_i == OP_ADDI || opcode_i == OP_ADDIU) ? 1'b1 : 1'b0;
                    if (opcode_i == OP_ANDI) begin
                        ctrl_o.alu_ctrl = ALU_AND;
                    end else if (opcode_i == OP_ORI) begin
                        ctrl_o.alu_ctrl = ALU_OR;
                    end else begin
                        ctrl_o.alu_ctrl = ALU_ADD;
                    end
                end
                OP_LW: begin
                    class_o           = CLS_LW;
                    ctrl_o.alu_src    = 1'b1;
                    ctrl_o.alu_ctrl   = ALU_ADD;
                    ctrl_o.sign2      = 1'b1;
                    ctrl_o.mem_to_reg = 1'b1;
                end
                OP_SW: begin
                    class_o         = CLS_SW;
                    ctrl_o.alu_src  = 1'b1;
                    ctrl_o.alu_ctrl = ALU_ADD;
                    ctrl_o.sign2    = 1'b1;
                end
                OP_BEQ: begin
                    class_o         = CLS_BEQ;
                    ctrl_o.alu_src  = 1'b0;
                    ctrl_o.alu_ctrl = ALU_SUB;
                    ctrl_o.sign2    = 1'b1;
                end
                OP_J: begin
                    class_o = CLS_J;
                end
                default: begin
                    class_o = CLS_NONE;
                    legal_o = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/mips_multicycle_sequencer.sv
// -----------------------------------------------------------------------------
// mips_multicycle_sequencer
// Multi-cycle control FSM for the Harvard Datapath. Holds PC and IR, fetches
// from instruction memory, decodes, and sequences the Datapath controls.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   start                      leave IDLE (ignored elsewhere)
//   imem_addr / imem_rdata     instruction fetch (combinational read)
//   beq, extend                Datapath equal flag and sign-extended immediate
//   rs, rt, rd, shamt, immediate   IR fields
//   sign1, sign2, RegDst, ALUsrc, ALUcontrol, MemtoReg, shift  static controls
//   RegWrite, MemWrite, MemRead, oe   per-phase enables (registered)
//   pc, halted, illegal        debug PC, halt status, sticky illegal flag
// -----------------------------------------------------------------------------
module mips_multicycle_sequencer
    import mips_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [5:0]  HALT_OPCODE = 6'h3F
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        beq,
    input  logic [31:0] extend,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [15:0] immediate,
    output logic        sign1,
    output logic        sign2,
    output logic        RegDst,
    output logic        RegWrite,
    output logic        ALUsrc,
    output logic        MemWrite,
    output logic        MemRead,
    output logic        MemtoReg,
    output logic        oe,
    output logic        shift,
    output logic [2:0]  ALUcontrol,
    output logic [31:0] pc,
    output logic        halted,
    output logic        illegal
);

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] ir_q;
    logic        regwrite_q;
    logic        memwrite_q;
    logic        memread_q;
    logic        oe_q;
    logic        halted_q;
    logic        illegal_q;

    ctrl_t       ctrl_s;
    iclass_e     class_s;
    logic        legal_s;

    mips_decoder #(
        .HALT_OPCODE (HALT_OPCODE)
    ) u_decoder (
        .opcode_i (ir_q[31:26]),
        .funct_i  (ir_q[5:0]),
        .ctrl_o   (ctrl_s),
        .class_o  (class_s),
        .legal_o  (legal_s)
    );

    // Sequencer FSM with PC/IR and registered per-phase enables.
    // Enables are set on the edge that enters their phase, so each is high for
    // exactly that phase and drops asynchronously with rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            ir_q       <= 32'h0000_0000;
            regwrite_q <= 1'b0;
            memwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            oe_q       <= 1'b0;
            halted_q   <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            regwrite_q <= 1'b0;
            memwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            oe_q       <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_FETCH;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_FETCH: begin
                    ir_q    <= imem_rdata;
                    pc_q    <= pc_q + 32'd4;
                    state_q <= ST_DECODE;
                end
                ST_DECODE: begin
                    if (class_s == CLS_HALT) begin
                        halted_q <= 1'b1;
                        state_q  <= ST_HALT;
                    end else if (!legal_s) begin
                        halted_q  <= 1'b1;
                        illegal_q <= 1'b1;
                        state_q   <= ST_HALT;
                    end else if (class_s == CLS_J) begin
                        pc_q    <= jump_target(pc_q[31:28], ir_q[25:0]);
                        state_q <= ST_FETCH;
                    end else begin
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    case (class_s)
                        CLS_BEQ: begin
                            // PC already points past the branch; offset comes from the Datapath
                            if (beq) begin
                                pc_q <= pc_q + (extend << 2);
                            end else begin
                                pc_q <= pc_q;
                            end
                            state_q <= ST_FETCH;
                        end
                        CLS_LW: begin
                            memread_q <= 1'b1;
                            oe_q      <= 1'b1;
                            state_q   <= ST_MEM;
                        end
                        CLS_SW: begin
                            memwrite_q <= 1'b1;
                            state_q    <= ST_MEM;
                        end
                        default: begin
                            regwrite_q <= 1'b1;
                            state_q    <= ST_WB;
                        end
                    endcase
                end
                ST_MEM: begin
                    if (class_s == CLS_LW) begin
                        regwrite_q <= 1'b1;
                        state_q    <= ST_WB;
                    end else begin
                        state_q <= ST_FETCH;
                    end
                end
                ST_WB: begin
                    state_q <= ST_FETCH;
                end
                ST_HALT: begin
                    state_q <= ST_HALT;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign imem_addr  = pc_q;
    assign pc         = pc_q;

    assign rs         = ir_q[25:21];
    assign rt         = ir_q[20:16];
    assign rd         = ir_q[15:11];
    assign shamt      = ir_q[10:6];
    assign immediate  = ir_q[15:0];

    assign RegDst     = ctrl_s.reg_dst;
    assign ALUsrc     = ctrl_s.alu_src;
    assign ALUcontrol = ctrl_s.alu_ctrl;
    assign sign1      = ctrl_s.sign1;
    assign sign2      = ctrl_s.sign2;
    assign shift      = ctrl_s.shift;
    assign MemtoReg   = ctrl_s.mem_to_reg;

    assign RegWrite   = regwrite_q;
    assign MemWrite   = memwrite_q;
    assign MemRead    = memread_q;
    assign oe         = oe_q;
    assign halted     = halted_q;
    assign illegal    = illegal_q;

endmodule
